mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits.
- TIMEOUT, 16, maximum cycles in a busy state without MemAck.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- IReq  in  1  fetch request.
- IAddr  in  ADDR_W  fetch address.
- IRdata  out  DATA_W  fetch read data.
- IReady  out  1  one-cycle fetch completion pulse.
- DReq  in  1  data request.
- DWe  in  1  data write enable.
- DAddr  in  ADDR_W  data address.
- DWdata  in  DATA_W  data write value.
- DRdata  out  DATA_W  data read data.
- DReady  out  1  one-cycle data completion pulse.
- MemReq  out  1  unified single-port memory request.
- MemWe  out  1  memory write enable.
- MemAddr  out  ADDR_W  memory address.
- MemWdata  out  DATA_W  memory write data.
- MemRdata  in  DATA_W  memory read data.
- MemAck  in  1  memory completion.
- StallI  out  1  fetch stall request.
- StallD  out  1  data stall request.
- Err  out  1  sticky timeout error.

Function
REQ-003 The block shall share one single-port memory between the fetch and data ports using FSM states IDLE, BUSY_I, BUSY_D and ERR.
REQ-004 A requester shall hold Req, address, We and Wdata stable until its Ready pulse; the block shall not check this.
REQ-005 In IDLE, the block shall grant data when DReq=1 and (IReq=0 or starve_cnt<STARVE_LIMIT), otherwise fetch when IReq=1.
REQ-006 On a grant, the block shall register address, We (forced to 0 for fetch) and Wdata into the Mem* outputs and enter BUSY_x next cycle.
REQ-007 In IDLE, a requester whose Ready is 1 in the current cycle shall not be granted, which prevents a double grant of a still-asserted Req.
REQ-008 MemReq shall be 1 exactly in BUSY_I and BUSY_D; MemWe/MemAddr/MemWdata shall stay constant throughout a busy state.
REQ-009 On MemAck=1 in BUSY_x, the block shall capture MemRdata into xRdata, pulse xReady for exactly the next cycle, and return to IDLE in that same next cycle.
REQ-010 xRdata shall hold its value until the next completion on that port; for data writes, DRdata shall also capture MemRdata.
REQ-011 Minimum latency shall be: Req seen in IDLE at cycle 0, MemReq at cycle 1, MemAck at cycle 1, Ready at cycle 2.
REQ-012 MemAck shall be ignored in IDLE and ERR.
REQ-013 starve_cnt shall increment (saturating at STARVE_LIMIT) on each data grant with IReq=1, and clear on a fetch grant or a data grant with IReq=0.
REQ-014 wait_cnt shall clear on entry to a busy state and increment each busy cycle without MemAck.
REQ-015 When wait_cnt reaches TIMEOUT-1 with MemAck=0, the block shall enter ERR next cycle.
REQ-016 In ERR: MemReq=0, Err=1, both Ready=0, and the state shall be held until reset.
REQ-017 StallI shall equal IReq & ~IReady and StallD shall equal DReq & ~DReady (combinational).

Reset
REQ-018 rst=0 shall asynchronously force: state IDLE; starve_cnt and wait_cnt 0; MemReq, MemWe, IReady, DReady and Err 0; MemAddr, MemWdata, IRdata and DRdata 0.
REQ-019 Reset mid-transaction shall abandon the access with no Ready pulse; operation shall resume from IDLE on the first edge after rst=1.

Structure
REQ-020 Package mem_arb_pkg shall hold the state enum (IDLE, BUSY_I, BUSY_D, ERR) and the default parameter constants.
REQ-021 The wait counter shall be a sub-module named timeout_counter (inputs clr and en; output expired).

Verification
REQ-022 Single fetch: IReq=1, IAddr=0x10, MemAck at cycle 1 with MemRdata=0xDEADBEEF -> IReady=1 at cycle 2, IRdata=0xDEADBEEF.
REQ-023 Contention: IReq and DReq both held for 12 requests, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I,... and StallI=1 while waiting.
REQ-024 Write: DReq=1, DWe=1, DAddr=0x40, DWdata=0x12345678, ack delayed 3 cycles -> MemWe=1 and fields stable for 4 busy cycles, DReady=1 for one cycle.
REQ-025 Timeout: fetch granted, MemAck never asserted, TIMEOUT=16 -> ERR after 16 busy cycles, Err=1, MemReq=0; a later MemAck has no effect.
REQ-026 Reset: rst=0 during BUSY_D -> all outputs 0 immediately, no DReady; after release, a new DReq is served with 2-cycle latency.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    ERR
  } arb_state_t;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled for port connection.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IRdata;
  logic              IReady;
  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWdata;
  logic [DATA_W-1:0] DRdata;
  logic              DReady;
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic              MemAck;
  logic              StallI;
  logic              StallD;
  logic              Err;

  // The arbiter itself.
  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata, MemAck,
    output IRdata, IReady, DRdata, DReady, MemReq, MemWe, MemAddr, MemWdata,
           StallI, StallD, Err
  );

  // The environment: requesters plus memory.
  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata, MemAck,
    input  IRdata, IReady, DRdata, DReady, MemReq, MemWe, MemAddr, MemWdata,
           StallI, StallD, Err
  );

endinterface

// File: rtl/mem_arbiter_timeout_counter.sv
// Busy-cycle counter; expired flags the last allowed cycle without an acknowledge.
module timeout_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = cnt_width(LIMIT - 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between a fetch and a data requester, with
// starvation-bounded data priority and a sticky timeout error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int SW = cnt_width(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t        state;
  logic [SW-1:0]     starve_cnt;
  logic              sel_d;
  logic              grant_d;
  logic              grant_i;
  logic              busy;
  logic              expired;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;

  // Data wins the selection unless fetch has waited too long; a requester still
  // showing its Ready pulse is held off so a lingering Req is not granted twice.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_d       = bus.DReq && (!bus.IReq || (starve_cnt < STARVE_MAX));
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    grant_addr  = bus.IAddr;
    grant_wdata = bus.MemWdata;
    if (state == IDLE) begin
      grant_d = sel_d && !bus.DReady;
      grant_i = !sel_d && bus.IReq && !bus.IReady;
    end
    if (sel_d) begin
      grant_addr  = bus.DAddr;
      grant_wdata = bus.DWdata;
    end
  end

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (grant_d || grant_i),
    .en      (busy && !bus.MemAck),
    .expired (expired)
  );

  // NOTE: every register here, data paths included, is cleared by reset so no X leaks out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      bus.MemReq   <= 1'b0;
      bus.MemWe    <= 1'b0;
      bus.MemAddr  <= '0;
      bus.MemWdata <= '0;
      bus.IReady   <= 1'b0;
      bus.DReady   <= 1'b0;
      bus.IRdata   <= '0;
      bus.DRdata   <= '0;
      bus.Err      <= 1'b0;
    end else begin
      bus.IReady <= 1'b0;
      bus.DReady <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            state        <= grant_d ? BUSY_D : BUSY_I;
            bus.MemReq   <= 1'b1;
            bus.MemWe    <= grant_d && bus.DWe;
            bus.MemAddr  <= grant_addr;
            bus.MemWdata <= grant_wdata;
          end
          if (grant_i || (grant_d && !bus.IReq)) begin
            starve_cnt <= '0;
          end else if (grant_d && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.MemAck) begin
            state      <= IDLE;
            bus.MemReq <= 1'b0;
            if (state == BUSY_I) begin
              bus.IRdata <= bus.MemRdata;
              bus.IReady <= 1'b1;
            end else begin
              bus.DRdata <= bus.MemRdata;
              bus.DReady <= 1'b1;
            end
          end else if (expired) begin
            state      <= ERR;
            bus.MemReq <= 1'b0;
            bus.Err    <= 1'b1;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.StallI = bus.IReq & ~bus.IReady;
  assign bus.StallD = bus.DReq & ~bus.DReady;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus contention,
// timeout and mid-transaction reset sequences.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4),
    .TIMEOUT      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mack;
    logic [31:0] mrdata;
    logic        chk_bus;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        irdy;
    logic        drdy;
    logic [31:0] irdata;
    logic [31:0] drdata;
    logic        stalli;
    logic        stalld;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input string name, input logic ireq, input logic [31:0] iaddr, input logic dreq,
    input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
    input logic mack, input logic [31:0] mrdata, input logic chk_bus, input logic mreq,
    input logic mwe, input logic [31:0] maddr, input logic [31:0] mwdata, input logic irdy,
    input logic drdy, input logic [31:0] irdata, input logic [31:0] drdata,
    input logic stalli, input logic stalld);
    vec_t v;
    v.name = name;  v.ireq = ireq;  v.iaddr = iaddr;  v.dreq = dreq;  v.dwe = dwe;
    v.daddr = daddr;  v.dwdata = dwdata;  v.mack = mack;  v.mrdata = mrdata;
    v.chk_bus = chk_bus;  v.mreq = mreq;  v.mwe = mwe;  v.maddr = maddr;  v.mwdata = mwdata;
    v.irdy = irdy;  v.drdy = drdy;  v.irdata = irdata;  v.drdata = drdata;
    v.stalli = stalli;  v.stalld = stalld;
    return v;
  endfunction

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic mack, input logic [31:0] mrdata);
    bus.IReq = ireq;  bus.IAddr = iaddr;  bus.DReq = dreq;  bus.DWe = dwe;
    bus.DAddr = daddr;  bus.DWdata = dwdata;  bus.MemAck = mack;  bus.MemRdata = mrdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          grants;
    int          busy_cycles;
    int          cyc;
    logic [31:0] exp_irdata;
    logic        got_err;
    checks   = 0;
    failures = 0;

    // Each record: inputs driven before an edge, outputs expected in the cycle after it.
    //          name        ireq iaddr         dreq dwe daddr         dwdata        mack mrdata        bus mreq mwe maddr         mwdata        irdy drdy irdata        drdata        sI sD
    vecs.push_back(mkv("idle_ack", 0, 32'h0,  0, 0, 32'h0,  32'h0,        1, 32'h55555555, 1, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mkv("f_req",    1, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'h0,        1, 1, 0, 32'h10, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mkv("f_ack",    1, 32'h10, 0, 0, 32'h0,  32'h0,        1, 32'hDEADBEEF, 0, 0, 0, 32'h0,  32'h0,        1, 0, 32'hDEADBEEF, 32'h0,        0, 0));
    vecs.push_back(mkv("f_hold",   1, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        1, 0));
    vecs.push_back(mkv("f_drop",   0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        0, 0));
    vecs.push_back(mkv("w_req",    0, 32'h0,  1, 1, 32'h40, 32'h12345678, 0, 32'h0,        1, 1, 1, 32'h40, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0,        0, 1));
    vecs.push_back(mkv("w_wait1",  0, 32'h0,  1, 1, 32'h40, 32'h12345678, 0, 32'h0,        1, 1, 1, 32'h40, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0,        0, 1));
    vecs.push_back(mkv("w_wait2",  0, 32'h0,  1, 1, 32'h40, 32'h12345678, 0, 32'h0,        1, 1, 1, 32'h40, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0,        0, 1));
    vecs.push_back(mkv("w_wait3",  0, 32'h0,  1, 1, 32'h40, 32'h12345678, 0, 32'h0,        1, 1, 1, 32'h40, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0,        0, 1));
    vecs.push_back(mkv("w_ack",    0, 32'h0,  1, 1, 32'h40, 32'h12345678, 1, 32'hA5A5A5A5, 0, 0, 0, 32'h0,  32'h0,        0, 1, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0));
    vecs.push_back(mkv("w_drop",   0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0));
    vecs.push_back(mkv("r_req",    0, 32'h0,  1, 0, 32'h44, 32'h0,        0, 32'h0,        1, 1, 0, 32'h44, 32'h0,        0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 1));
    vecs.push_back(mkv("r_ack",    0, 32'h0,  1, 0, 32'h44, 32'h0,        1, 32'h0000BEEF, 0, 0, 0, 32'h0,  32'h0,        0, 1, 32'hDEADBEEF, 32'h0000BEEF, 0, 0));
    vecs.push_back(mkv("f2_req",   1, 32'h20, 0, 0, 32'h0,  32'h0,        0, 32'h0,        1, 1, 0, 32'h20, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0000BEEF, 1, 0));
    vecs.push_back(mkv("f2_ack",   1, 32'h20, 0, 0, 32'h0,  32'h0,        1, 32'h13579BDF, 0, 0, 0, 32'h0,  32'h0,        1, 0, 32'h13579BDF, 32'h0000BEEF, 0, 0));
    vecs.push_back(mkv("f2_drop",  0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h13579BDF, 32'h0000BEEF, 0, 0));

    // Reset state
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst.MemReq", bus.MemReq, 0);
    check("rst.MemWe", bus.MemWe, 0);
    check("rst.MemAddr", bus.MemAddr, 0);
    check("rst.IReady", bus.IReady, 0);
    check("rst.DReady", bus.DReady, 0);
    check("rst.IRdata", bus.IRdata, 0);
    check("rst.DRdata", bus.DRdata, 0);
    check("rst.Err", bus.Err, 0);
    rst = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].daddr,
            vecs[i].dwdata, vecs[i].mack, vecs[i].mrdata);
      @(negedge clk);
      check({vecs[i].name, ".MemReq"}, bus.MemReq, vecs[i].mreq);
      if (vecs[i].chk_bus) begin
        check({vecs[i].name, ".MemWe"}, bus.MemWe, vecs[i].mwe);
        check({vecs[i].name, ".MemAddr"}, bus.MemAddr, vecs[i].maddr);
        check({vecs[i].name, ".MemWdata"}, bus.MemWdata, vecs[i].mwdata);
      end
      check({vecs[i].name, ".IReady"}, bus.IReady, vecs[i].irdy);
      check({vecs[i].name, ".DReady"}, bus.DReady, vecs[i].drdy);
      check({vecs[i].name, ".IRdata"}, bus.IRdata, vecs[i].irdata);
      check({vecs[i].name, ".DRdata"}, bus.DRdata, vecs[i].drdata);
      check({vecs[i].name, ".StallI"}, bus.StallI, vecs[i].stalli);
      check({vecs[i].name, ".StallD"}, bus.StallD, vecs[i].stalld);
      check({vecs[i].name, ".Err"}, bus.Err, 0);
    end

    // Contention: both held, memory acks at once; expect D,D,D,D,I repeating
    exp_irdata = 32'h13579BDF;
    drive(1, 32'h100, 1, 0, 32'h200, 32'h0, 0, 32'h0);
    grants = 0;
    cyc    = 0;
    while (grants < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.MemReq) begin
        check($sformatf("cont.grant%0d", grants), bus.MemAddr,
              (grants % 5 == 4) ? 32'h100 : 32'h200);
        if (bus.MemAddr == 32'h200) check($sformatf("cont.stalli%0d", grants), bus.StallI, 1);
        if (bus.MemAddr == 32'h100) exp_irdata = 32'hF0000000 | grants;
        bus.MemRdata = 32'hF0000000 | grants;
        bus.MemAck   = 1'b1;
        grants++;
      end else begin
        bus.MemAck = 1'b0;
      end
    end
    check("cont.grant_count", grants, 12);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("cont.IRdata", bus.IRdata, exp_irdata);

    // Timeout: fetch never acknowledged
    drive(1, 32'h300, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    busy_cycles = 0;
    got_err     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.Err) begin
        got_err = 1'b1;
        break;
      end
      if (bus.MemReq) busy_cycles++;
    end
    check("tmo.reached", got_err, 1);
    check("tmo.busy_cycles", busy_cycles, 16);
    check("tmo.MemReq", bus.MemReq, 0);
    check("tmo.IReady", bus.IReady, 0);
    bus.DReq     = 1'b1;
    bus.DAddr    = 32'h400;
    bus.MemAck   = 1'b1;
    bus.MemRdata = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("err%0d.Err", c), bus.Err, 1);
      check($sformatf("err%0d.MemReq", c), bus.MemReq, 0);
      check($sformatf("err%0d.IReady", c), bus.IReady, 0);
      check($sformatf("err%0d.DReady", c), bus.DReady, 0);
      check($sformatf("err%0d.IRdata", c), bus.IRdata, exp_irdata);
    end
    check("err.StallD", bus.StallD, 1);

    // Reset out of ERR, then reset again in the middle of a data access
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst2.Err", bus.Err, 0);
    rst = 1'b1;
    drive(0, 32'h0, 1, 1, 32'h80, 32'hFFFF0000, 0, 32'h0);
    @(negedge clk);
    check("rb.MemReq", bus.MemReq, 1);
    check("rb.MemWe", bus.MemWe, 1);
    #2 rst = 1'b0;
    #1;
    check("rb.async_MemReq", bus.MemReq, 0);
    check("rb.async_MemWe", bus.MemWe, 0);
    check("rb.async_MemAddr", bus.MemAddr, 0);
    check("rb.async_MemWdata", bus.MemWdata, 0);
    check("rb.async_DRdata", bus.DRdata, 0);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("rb.no_DReady", bus.DReady, 0);
    rst = 1'b1;
    drive(0, 32'h0, 1, 0, 32'h84, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("rb2.MemReq", bus.MemReq, 1);
    check("rb2.MemAddr", bus.MemAddr, 32'h84);
    check("rb2.MemWe", bus.MemWe, 0);
    bus.MemAck   = 1'b1;
    bus.MemRdata = 32'h0BADF00D;
    @(negedge clk);
    check("rb2.DReady", bus.DReady, 1);
    check("rb2.DRdata", bus.DRdata, 32'h0BADF00D);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("rb2.DReady_pulse", bus.DReady, 0);
    check("rb2.DRdata_hold", bus.DRdata, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
